// File: rtl/seg7_scan_decoder_if.sv
// Pin-side and result-side signals of the 7-segment scan decoder.
// master = the display driver (and the bench); slave = the decoder itself.
interface seg7_scan_decoder_if;
    logic        a, b, c, d, e, f, g;
    logic        w, x, y, z;
    logic [15:0] value;
    logic [3:0]  dig_valid;
    logic        upd;
    logic        frame;
    logic        seg_err;
    logic        an_err;
    logic        timeout;

    modport master (
        output a, b, c, d, e, f, g,
        output w, x, y, z,
        input  value, dig_valid, upd, frame, seg_err, an_err, timeout
    );

    modport slave (
        input  a, b, c, d, e, f, g,
        input  w, x, y, z,
        output value, dig_valid, upd, frame, seg_err, an_err, timeout
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Loopback receiver for a multiplexed 4-digit 7-segment display: debounces each scanned
// pattern, decodes it back to a hex nibble and rebuilds the displayed 16-bit value.
module seg7_scan_decoder #(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1000000,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input logic                clk,
    input logic                clr_n,
    seg7_scan_decoder_if.slave bus
);

    localparam int CNT_W = $clog2(STABLE_CYC + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYC);
    localparam logic [3:0]  AN_IDLE  = AN_ACT_LOW  ? 4'hF  : 4'h0;
    localparam logic [6:0]  SEG_IDLE = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic [10:0] PIN_IDLE = {AN_IDLE, SEG_IDLE};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DWELL
    } state_t;

    // The CAPTURE cycle itself consumes the last equal sample, so a 2-sample
    // filter has to jump straight there from the first sighting.
    localparam state_t ST_FIRST = (STABLE_CYC <= 2) ? ST_CAPTURE : ST_SETTLE;

    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        r = 5'h00;
        case (s)
            7'h3F: r = {1'b1, 4'h0};
            7'h06: r = {1'b1, 4'h1};
            7'h5B: r = {1'b1, 4'h2};
            7'h4F: r = {1'b1, 4'h3};
            7'h66: r = {1'b1, 4'h4};
            7'h6D: r = {1'b1, 4'h5};
            7'h7D: r = {1'b1, 4'h6};
            7'h07: r = {1'b1, 4'h7};
            7'h7F: r = {1'b1, 4'h8};
            7'h6F: r = {1'b1, 4'h9};
            7'h77: r = {1'b1, 4'hA};
            7'h7C: r = {1'b1, 4'hB};
            7'h39: r = {1'b1, 4'hC};
            7'h5E: r = {1'b1, 4'hD};
            7'h79: r = {1'b1, 4'hE};
            7'h71: r = {1'b1, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    logic [10:0]      pins;
    logic [10:0]      sync1, sync2;
    logic [10:0]      norm;
    logic             any_an;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [10:0]      hold_q, hold_d;
    logic             cap_fire;

    assign pins = {bus.w, bus.x, bus.y, bus.z,
                   bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};

    // Two-flop synchroniser; idle level depends on the pin polarity.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            sync1 <= PIN_IDLE;
            sync2 <= PIN_IDLE;
        end else begin
            sync1 <= pins;
            sync2 <= sync1;
        end
    end

    assign norm    = sync2 ^ PIN_IDLE;
    assign any_an  = |norm[10:7];
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        cap_fire = 1'b0;
        if (state_q == ST_IDLE || norm != hold_q) begin
            hold_d = norm;
            if (any_an) begin
                cnt_d   = CNT_W'(1);
                state_d = ST_FIRST;
            end else begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= CNT_LAST) begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    cap_fire = 1'b1;
                    state_d  = ST_DWELL;
                end
                default: state_d = state_q;
            endcase
        end
    end

    logic [3:0] cap_an;
    logic [6:0] cap_seg;
    logic       cap_one;
    logic [1:0] cap_idx;
    logic       cap_hit;
    logic [3:0] cap_nib;

    assign cap_an  = hold_q[10:7];
    assign cap_seg = hold_q[6:0];

    always_comb begin
        cap_one = (cap_an != 4'd0) && ((cap_an & (cap_an - 4'd1)) == 4'd0);
        cap_idx = 2'd0;
        case (cap_an)
            4'b0010: cap_idx = 2'd1;
            4'b0100: cap_idx = 2'd2;
            4'b1000: cap_idx = 2'd3;
            default: cap_idx = 2'd0;
        endcase
        {cap_hit, cap_nib} = seg_decode(cap_seg);
    end

    logic [15:0]     value_q;
    logic [3:0]      valid_q, seen_q;
    logic            upd_q, frame_q, seg_err_q, an_err_q, timeout_q;
    logic [TO_W-1:0] idle_q;

    // A valid single-digit capture wins over a timeout expiring on the same edge.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            value_q   <= '0;
            valid_q   <= '0;
            seen_q    <= '0;
            upd_q     <= 1'b0;
            frame_q   <= 1'b0;
            seg_err_q <= 1'b0;
            an_err_q  <= 1'b0;
            timeout_q <= 1'b0;
            idle_q    <= '0;
        end else begin
            upd_q     <= 1'b0;
            frame_q   <= 1'b0;
            seg_err_q <= 1'b0;
            an_err_q  <= 1'b0;
            if (cap_fire && cap_one) begin
                upd_q     <= 1'b1;
                timeout_q <= 1'b0;
                idle_q    <= '0;
                if (cap_hit) begin
                    value_q[{cap_idx, 2'b00} +: 4] <= cap_nib;
                    valid_q[cap_idx]               <= 1'b1;
                end else begin
                    valid_q[cap_idx] <= 1'b0;
                    seg_err_q        <= (cap_seg != 7'h00);
                end
                if (cap_idx == 2'd0 && seen_q[3:1] == 3'b111) begin
                    frame_q <= 1'b1;
                    seen_q  <= '0;
                end else begin
                    seen_q[cap_idx] <= 1'b1;
                end
            end else begin
                an_err_q <= cap_fire;
                if (idle_q != TO_MAX) begin
                    idle_q <= idle_q + TO_W'(1);
                    if (idle_q == TO_MAX - TO_W'(1)) begin
                        timeout_q <= 1'b1;
                        valid_q   <= '0;
                    end
                end
            end
        end
    end

    assign bus.value     = value_q;
    assign bus.dig_valid = valid_q;
    assign bus.upd       = upd_q;
    assign bus.frame     = frame_q;
    assign bus.seg_err   = seg_err_q;
    assign bus.an_err    = an_err_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: each driven pattern predicts its capture,
// and a negedge monitor pops and compares whenever the decoder reports one.
module tb_seg7_scan_decoder;

    localparam int STABLE = 4;
    localparam int TMO    = 50;

    typedef struct {
        int          cyc;
        logic [15:0] value;
        logic [3:0]  valid;
        logic        frame;
        logic        seg_err;
        logic        an_err;
    } exp_t;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_decoder_if bus();

    seg7_scan_decoder #(
        .STABLE_CYC (STABLE),
        .TIMEOUT_CYC(TMO),
        .SEG_ACT_LOW(1'b1),
        .AN_ACT_LOW (1'b1)
    ) dut (
        .clk  (clk),
        .clr_n(clr_n),
        .bus  (bus.slave)
    );

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [15:0] m_value = '0;
    logic [3:0]  m_valid = '0;
    logic [3:0]  m_mask  = '0;
    int          m_last  = 0;
    logic [10:0] prev    = '0;
    logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    // Monitor: every reported capture must match the oldest prediction.
    always @(negedge clk) begin
        if (bus.upd || bus.an_err) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_capture", sb.size(), 1);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("cap_cycle", cyc, mon_e.cyc);
                checkOutput("cap_upd", bus.upd, !mon_e.an_err);
                checkOutput("cap_an_err", bus.an_err, mon_e.an_err);
                checkOutput("cap_value", bus.value, mon_e.value);
                checkOutput("cap_valid", bus.dig_valid, mon_e.valid);
                checkOutput("cap_frame", bus.frame, mon_e.frame);
                checkOutput("cap_seg_err", bus.seg_err, mon_e.seg_err);
            end
        end else if (bus.frame || bus.seg_err) begin
            checkOutput("stray_pulse", {bus.frame, bus.seg_err}, 0);
        end
    end

    task automatic setPins(input logic [3:0] an, input logic [6:0] seg);
        {bus.w, bus.x, bus.y, bus.z} = ~an;
        {bus.g, bus.f, bus.e, bus.d, bus.c, bus.b, bus.a} = ~seg;
    endtask

    task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int hold);
        exp_t e;
        int   idx;
        int   nib;
        setPins(an, seg);
        if (an != 4'd0 && {an, seg} != prev && hold >= STABLE) begin
            e.cyc     = cyc + STABLE + 2;
            e.frame   = 1'b0;
            e.seg_err = 1'b0;
            e.an_err  = 1'b0;
            if ($countones(an) == 1) begin
                if (e.cyc - m_last > TMO) m_valid = '0;
                idx = (an == 4'b1000) ? 3 : (an == 4'b0100) ? 2 : (an == 4'b0010) ? 1 : 0;
                nib = -1;
                for (int k = 0; k < 16; k++) if (seg_tab[k] == seg) nib = k;
                if (nib >= 0) begin
                    m_value[idx*4 +: 4] = 4'(nib);
                    m_valid[idx]        = 1'b1;
                end else begin
                    m_valid[idx] = 1'b0;
                    e.seg_err    = (seg != 7'h00);
                end
                if (idx == 0 && m_mask[3:1] == 3'b111) begin
                    e.frame = 1'b1;
                    m_mask  = '0;
                end else begin
                    m_mask[idx] = 1'b1;
                end
                m_last = e.cyc;
            end else begin
                e.an_err = 1'b1;
                if (e.cyc - m_last >= TMO) m_valid = '0;
            end
            e.value = m_value;
            e.valid = m_valid;
            sb.push_back(e);
        end
        prev = {an, seg};
        repeat (hold) @(negedge clk);
    endtask

    // Called at a negedge; pending predictions are dropped because reset aborts them.
    task automatic doReset(input int cycles);
        int overdue;
        clr_n   = 1'b0;
        setPins(4'd0, 7'd0);
        prev    = '0;
        overdue = 0;
        foreach (sb[i]) if (sb[i].cyc <= cyc) overdue++;
        checkOutput("missed_capture", overdue, 0);
        sb.delete();
        m_value = '0;
        m_valid = '0;
        m_mask  = '0;
        repeat (cycles) @(negedge clk);
        clr_n  = 1'b1;
        m_last = cyc;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        setPins(4'd0, 7'd0);
        @(negedge clk);
        doReset(3);

        $display("[TB] reset state");
        checkOutput("rst_value", bus.value, 16'h0000);
        checkOutput("rst_valid", bus.dig_valid, 4'h0);
        checkOutput("rst_pulses", {bus.upd, bus.frame, bus.seg_err, bus.an_err}, 4'h0);
        checkOutput("rst_timeout", bus.timeout, 1'b0);

        $display("[TB] single digit and hex letters on digit0");
        applyStimulus(4'b0001, 7'h66, 8);
        checkOutput("d0_value", bus.value, 16'h0004);
        checkOutput("d0_valid", bus.dig_valid, 4'b0001);
        applyStimulus(4'b0001, 7'h7C, 8);
        applyStimulus(4'b0001, 7'h71, 8);
        checkOutput("d0_hex_value", bus.value, 16'h000F);

        $display("[TB] full scan and timeout");
        doReset(2);
        applyStimulus(4'b1000, 7'h06, 24);
        applyStimulus(4'b0100, 7'h5B, 24);
        applyStimulus(4'b0010, 7'h4F, 24);
        applyStimulus(4'b0001, 7'h66, 24);
        checkOutput("scan_value", bus.value, 16'h1234);
        checkOutput("scan_valid", bus.dig_valid, 4'hF);
        checkOutput("scan_timeout", bus.timeout, 1'b0);
        applyStimulus(4'b0000, 7'h00, 4);
        waitUntil(m_last + TMO - 1);
        checkOutput("tmo_before", bus.timeout, 1'b0);
        @(negedge clk);
        checkOutput("tmo_at", bus.timeout, 1'b1);
        checkOutput("tmo_valid_clr", bus.dig_valid, 4'h0);
        checkOutput("tmo_value_kept", bus.value, 16'h1234);
        applyStimulus(4'b0001, 7'h3F, 8);
        checkOutput("tmo_cleared", bus.timeout, 1'b0);

        $display("[TB] illegal segments, multiple anodes, blank");
        doReset(2);
        applyStimulus(4'b0100, 7'h49, 8);
        applyStimulus(4'b1001, 7'h3F, 8);
        applyStimulus(4'b0010, 7'h00, 8);
        applyStimulus(4'b0001, 7'h77, 8);
        checkOutput("err_value", bus.value, 16'h000A);
        checkOutput("err_valid", bus.dig_valid, 4'b0001);

        $display("[TB] glitching pattern");
        doReset(2);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4'b0001, (i % 2 == 0) ? 7'h06 : 7'h5B, 3);
        end
        applyStimulus(4'b0001, 7'h06, 1);
        checkOutput("glitch_tmo_before", bus.timeout, 1'b0);
        applyStimulus(4'b0001, 7'h06, 1);
        checkOutput("glitch_tmo_at", bus.timeout, 1'b1);
        applyStimulus(4'b0001, 7'h06, 1);
        applyStimulus(4'b0001, 7'h5B, 3);
        applyStimulus(4'b0001, 7'h06, 3);
        checkOutput("glitch_tmo_held", bus.timeout, 1'b1);

        $display("[TB] reset during settle");
        applyStimulus(4'b0010, 7'h06, 8);
        checkOutput("pre_rst_value", bus.value, 16'h0010);
        applyStimulus(4'b0001, 7'h4F, 3);
        doReset(2);
        repeat (12) @(negedge clk);
        checkOutput("midrst_value", bus.value, 16'h0000);
        checkOutput("midrst_valid", bus.dig_valid, 4'h0);
        checkOutput("midrst_timeout", bus.timeout, 1'b0);

        checkOutput("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
